// File: rtl/fram_xbar_if.sv
// Client-side bus of the feature-RAM crossbar.
// Groups the per-port read/write request handshakes and the read response
// channel. 'master' is the client side (drives requests, sinks responses);
// 'slave' is the crossbar side.
//   rd_valid/rd_addr     -> read request per read port
//   rd_ready             <- read request accepted this cycle
//   rd_rsp_valid/_data   <- read response, fixed latency after accept
//   wr_valid/wr_addr/_data -> write request per write port
//   wr_ready             <- write accepted this cycle
interface fram_xbar_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int RD_PORTS   = 2,
    parameter int WR_PORTS   = 1
);
    logic [RD_PORTS-1:0]                 rd_valid;
    logic [RD_PORTS-1:0]                 rd_ready;
    logic [RD_PORTS-1:0][ADDR_WIDTH-1:0] rd_addr;
    logic [RD_PORTS-1:0]                 rd_rsp_valid;
    logic [RD_PORTS-1:0][DATA_WIDTH-1:0] rd_rsp_data;
    logic [WR_PORTS-1:0]                 wr_valid;
    logic [WR_PORTS-1:0]                 wr_ready;
    logic [WR_PORTS-1:0][ADDR_WIDTH-1:0] wr_addr;
    logic [WR_PORTS-1:0][DATA_WIDTH-1:0] wr_data;

    modport master (
        output rd_valid, rd_addr, wr_valid, wr_addr, wr_data,
        input  rd_ready, rd_rsp_valid, rd_rsp_data, wr_ready
    );

    modport slave (
        input  rd_valid, rd_addr, wr_valid, wr_addr, wr_data,
        output rd_ready, rd_rsp_valid, rd_rsp_data, wr_ready
    );
endinterface

// File: rtl/fram_xbar.sv
// Multi-port crossbar between feature-RAM clients and a banked BRAM array.
// Every bank has its own round-robin arbiter over all requesters (write
// ports first, then read ports); losers stall with ready low. Read data
// returns in order a fixed RD_LATENCY cycles after accept.
// Ports:
//   clk, rst      single clock, asynchronous active-high reset
//   bus           client request/response bus (fram_xbar_if.slave)
//   bram_*        per-bank BRAM port: addr, wdata, we, en out; rdata in
//   stat_clr      synchronous clear of stall_cnt
//   stall_cnt     saturating count of cycles with any stalled request
// STALL_CNT_WIDTH (1..32) sets where the stall counter saturates; the
// output is always 32 bits, zero-extended.
module fram_xbar #(
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 32,
    parameter int BANK_NUM        = 8,
    parameter int RD_PORTS        = 2,
    parameter int WR_PORTS        = 1,
    parameter int RD_LATENCY      = 1,
    parameter int BANK_MAP        = 0,
    parameter int STALL_CNT_WIDTH = 32,
    localparam int BW = $clog2(BANK_NUM),
    localparam int LW = ADDR_WIDTH - BW
) (
    input  logic                               clk,
    input  logic                               rst,
    fram_xbar_if.slave                         bus,
    output logic [BANK_NUM-1:0][LW-1:0]        bram_addr,
    output logic [BANK_NUM-1:0][DATA_WIDTH-1:0] bram_wdata,
    output logic [BANK_NUM-1:0]                bram_we,
    output logic [BANK_NUM-1:0]                bram_en,
    input  logic [BANK_NUM-1:0][DATA_WIDTH-1:0] bram_rdata,
    input  logic                               stat_clr,
    output logic [31:0]                        stall_cnt
);
    localparam int NREQ = WR_PORTS + RD_PORTS;
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;

    function automatic logic [BW-1:0] bank_of(input logic [ADDR_WIDTH-1:0] a);
        if (BANK_MAP == 0) return a[ADDR_WIDTH-1 -: BW];
        return a[BW-1:0];
    endfunction

    function automatic logic [LW-1:0] local_of(input logic [ADDR_WIDTH-1:0] a);
        if (BANK_MAP == 0) return a[LW-1:0];
        return a[ADDR_WIDTH-1:BW];
    endfunction

    // Flattened requester view: index 0..WR_PORTS-1 writes, then reads.
    logic [NREQ-1:0]                 req_valid;
    logic [NREQ-1:0]                 req_grant;
    logic [NREQ-1:0][BW-1:0]         req_bank;
    logic [NREQ-1:0][LW-1:0]         req_local;
    logic [NREQ-1:0][DATA_WIDTH-1:0] req_wdata;

    logic [BANK_NUM-1:0]             bank_gnt;
    logic [BANK_NUM-1:0][IW-1:0]     bank_idx;
    logic [BANK_NUM-1:0][IW-1:0]     rr_q, rr_d;

    logic [RD_PORTS-1:0][RD_LATENCY-1:0]         rsp_vld_q, rsp_vld_d;
    logic [RD_PORTS-1:0][RD_LATENCY-1:0][BW-1:0] rsp_bank_q, rsp_bank_d;

    logic [STALL_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic                       any_stall;

    always_comb begin
        for (int i = 0; i < WR_PORTS; i++) begin
            // Nothing is granted while reset is held.
            req_valid[i] = bus.wr_valid[i] & ~rst;
            req_bank[i]  = bank_of(bus.wr_addr[i]);
            req_local[i] = local_of(bus.wr_addr[i]);
            req_wdata[i] = bus.wr_data[i];
        end
        for (int p = 0; p < RD_PORTS; p++) begin
            req_valid[WR_PORTS+p] = bus.rd_valid[p] & ~rst;
            req_bank[WR_PORTS+p]  = bank_of(bus.rd_addr[p]);
            req_local[WR_PORTS+p] = local_of(bus.rd_addr[p]);
            req_wdata[WR_PORTS+p] = '0;
        end
    end

    // Per-bank round robin: first valid requester for this bank, searching
    // upward cyclically from rr_q[b]; the pointer moves past the winner.
    always_comb begin
        int idx;
        idx       = 0;
        bank_gnt  = '0;
        bank_idx  = '0;
        req_grant = '0;
        rr_d      = rr_q;
        for (int b = 0; b < BANK_NUM; b++) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (int'(rr_q[b]) + k) % NREQ;
                if (!bank_gnt[b] && req_valid[idx] && (req_bank[idx] == BW'(b))) begin
                    bank_gnt[b]    = 1'b1;
                    bank_idx[b]    = IW'(idx);
                    req_grant[idx] = 1'b1;
                end
            end
            if (bank_gnt[b]) begin
                rr_d[b] = IW'((int'(bank_idx[b]) + 1) % NREQ);
            end
        end
    end

    always_comb begin
        for (int b = 0; b < BANK_NUM; b++) begin
            bram_en[b]    = bank_gnt[b];
            bram_we[b]    = bank_gnt[b] && (int'(bank_idx[b]) < WR_PORTS);
            bram_addr[b]  = bank_gnt[b] ? req_local[bank_idx[b]] : '0;
            bram_wdata[b] = bram_we[b] ? req_wdata[bank_idx[b]] : '0;
        end
        for (int i = 0; i < WR_PORTS; i++) begin
            bus.wr_ready[i] = req_grant[i];
        end
        for (int p = 0; p < RD_PORTS; p++) begin
            bus.rd_ready[p] = req_grant[WR_PORTS+p];
        end
    end

    // Response tracking: stage 0 captures the accept, last stage lines up
    // with the BRAM output of the accepted bank.
    always_comb begin
        for (int p = 0; p < RD_PORTS; p++) begin
            rsp_vld_d[p][0]  = req_grant[WR_PORTS+p];
            rsp_bank_d[p][0] = req_bank[WR_PORTS+p];
            for (int s = 1; s < RD_LATENCY; s++) begin
                rsp_vld_d[p][s]  = rsp_vld_q[p][s-1];
                rsp_bank_d[p][s] = rsp_bank_q[p][s-1];
            end
            bus.rd_rsp_valid[p] = rsp_vld_q[p][RD_LATENCY-1];
            bus.rd_rsp_data[p]  = rsp_vld_q[p][RD_LATENCY-1]
                                ? bram_rdata[rsp_bank_q[p][RD_LATENCY-1]] : '0;
        end
    end

    always_comb begin
        any_stall   = |(req_valid & ~req_grant);
        stall_cnt_d = stall_cnt_q;
        if (stat_clr) begin
            stall_cnt_d = '0;
        end else if (any_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        stall_cnt = 32'(stall_cnt_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q        <= '0;
            rsp_vld_q   <= '0;
            rsp_bank_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            rr_q        <= rr_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_bank_q  <= rsp_bank_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule

// File: doc/fram_xbar.md
# fram_xbar

Parametrised multi-port crossbar between the NPU's feature-RAM clients and the banked BRAM array (PORTB side). It carries any number of read and write ports with valid/ready handshakes. Each bank has a round-robin arbiter, so bank conflicts stall the losing requester instead of dropping its request. Read responses come back in order after a fixed, parametrised BRAM latency. Bank selection is either high-bit (block) or low-bit (interleaved), and stall cycles are counted for profiling.

## Interface
- ADDR_WIDTH, 16, global feature-RAM word address width
- DATA_WIDTH, 32, word width
- BANK_NUM, 8, number of BRAM banks; power of two, ≥2
- RD_PORTS, 2, number of read ports, ≥1
- WR_PORTS, 1, number of write ports, ≥1
- RD_LATENCY, 1, BRAM en-to-dout cycles, 1..4
- BANK_MAP, 0, 0 = bank from address MSBs, 1 = bank from address LSBs (interleaved)
- Ports use BW = log2(BANK_NUM) and LW = ADDR_WIDTH-BW.
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- rd_valid  in  RD_PORTS  read request valid, per port
- rd_ready  out  RD_PORTS  read request accepted this cycle
- rd_addr  in  RD_PORTS×ADDR_WIDTH  read address, per port
- rd_rsp_valid  out  RD_PORTS  read data valid
- rd_rsp_data  out  RD_PORTS×DATA_WIDTH  read data
- wr_valid  in  WR_PORTS  write request valid
- wr_ready  out  WR_PORTS  write accepted this cycle
- wr_addr  in  WR_PORTS×ADDR_WIDTH  write address
- wr_data  in  WR_PORTS×DATA_WIDTH  write data
- bram_addr  out  BANK_NUM×LW  bank-local address
- bram_wdata  out  BANK_NUM×DATA_WIDTH  bank write data
- bram_we  out  BANK_NUM  bank write enable
- bram_en  out  BANK_NUM  bank enable
- bram_rdata  in  BANK_NUM×DATA_WIDTH  bank read data, RD_LATENCY after en
- stat_clr  in  1  synchronous clear of stall_cnt
- stall_cnt  out  32  cycles with at least one stalled request, saturating

## Operation
- **Address split.**
  - BANK_MAP=0: bank = addr[ADDR_WIDTH-1 -: BW], local = addr[LW-1:0].
  - BANK_MAP=1: bank = addr[BW-1:0], local = addr[ADDR_WIDTH-1:BW].
- **Requester order.** Indices 0..WR_PORTS-1 are the write ports; WR_PORTS..WR_PORTS+RD_PORTS-1 are the read ports.
- **Per-bank arbitration.**
  - Each bank grants at most one requester per cycle.
  - The winner is the first valid requester targeting that bank, searching upward cyclically from that bank's pointer rr[b].
  - On a grant to index g, rr[b] ← (g+1) mod (WR_PORTS+RD_PORTS). With no grant, rr[b] holds.
  - Any requester that waits is granted within WR_PORTS+RD_PORTS-1 cycles.
- **Handshake.**
  - ready = granted. This is combinational from the same-cycle valids and addresses.
  - Requesters must not derive valid from ready.
  - A stalled requester must hold valid, addr and data stable until ready.
- **Bank drive for a granted write:** en=1, we=1, addr=local, wdata=wr_data.
- **Bank drive for a granted read:** en=1, we=0, addr=local, wdata=0.
- **Ungranted bank:** all bank outputs are 0.
- **Read return.**
  - Each read port has a RD_LATENCY-deep shift register of {valid, bank}.
  - rd_rsp_valid[p] and rd_rsp_data[p] = bram_rdata[bank] appear exactly RD_LATENCY cycles after the accept.
  - There is no response backpressure; consumers must always sink responses.
- **Same-address hazard.** A read and a write to the same address cannot be granted in the same cycle, because both target one bank. Order between them is set by arbitration.
- **stall_cnt.**
  - Increments by 1 in each cycle where any valid is not ready; saturates at 0xFFFF_FFFF.
  - stat_clr forces it to 0, and wins over an increment in the same cycle.

## Timing
- **Reset values.**
  - All rr[b] = 0.
  - All response shift registers are cleared, so rd_rsp_valid = 0 and rd_rsp_data = 0.
  - stall_cnt = 0.
  - bram_* and ready outputs follow the request inputs combinationally; with no valid inputs they are 0.
- **Reset mid-operation.** In-flight responses are discarded. No rd_rsp_valid appears for any read accepted before reset.
- **While rst is high,** ready=0 and bram_en=0 regardless of valid.
- **Throughput.** With no conflicts, every port is accepted every cycle; BANK_NUM is the peak accesses per cycle.
- **Back-to-back reads** on one port return one response per cycle, in request order.
- **stall_cnt** updates on the clock edge following the stalled cycle.

## Test plan
- **Parallel reads, no conflict.** Reset, RD_LATENCY=1, BANK_MAP=0, BANK_NUM=8, ADDR_WIDTH=16. Port0 reads 0x0004 (bank 0) and port1 reads 0x2004 (bank 1) in the same cycle -> both ready=1. One cycle later, each port's rsp_data equals its bank's rdata and stall_cnt stays 0.
- **Write/read conflict with fairness.** Wr0 writes 0x1000 (bank 0) while rd0 reads 0x0010 (bank 0), both valid for 3 cycles -> grants alternate wr, rd, wr. Stalled cycles advance stall_cnt by exactly 1 each.
- **Interleaved mapping.** BANK_MAP=1, addresses 0x0000..0x0007 issued one per cycle on rd0 -> bram_en walks banks 0..7 with local address 0. Responses arrive in order with RD_LATENCY=2.
- **Saturation and clear.** Preload the stall condition until stall_cnt = 0xFFFF_FFFE, then stall 3 more cycles -> stall_cnt holds 0xFFFF_FFFF. Assert stat_clr together with a stall -> stall_cnt = 0.
- **Reset mid-flight.** RD_LATENCY=3, two reads accepted, then rst pulsed 1 cycle later -> rd_rsp_valid stays 0 forever after. rr pointers restart, so wr0 wins the first post-reset conflict.
- **Full-load random.** All ports valid every cycle with random addresses for 10k cycles -> data matches a scoreboard memory model, no port waits more than WR_PORTS+RD_PORTS-1 cycles, and there is at most one en per bank per cycle.
